// File: rtl/keypad_pkg.sv
// Shared keypad types and constants: column reset pattern, event payload, default 4x4 ASCII layout.
package keypad_pkg;

    localparam int unsigned KEY_CODE_MAX_W = 8;

    // Column 0 driven out of reset; truncated to the column count by users.
    localparam logic [31:0] COL_RESET = 32'h0000_0001;

    typedef struct packed {
        logic                      press;
        logic [KEY_CODE_MAX_W-1:0] code;
    } key_event_t;

    // Code = col*4 + row for the standard 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D layout.
    localparam logic [15:0][7:0] ASCII_MAP_4X4 = {
        8'h44, 8'h43, 8'h42, 8'h41,
        8'h23, 8'h39, 8'h36, 8'h33,
        8'h30, 8'h38, 8'h35, 8'h32,
        8'h2A, 8'h37, 8'h34, 8'h31
    };

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event stream: valid/ready handshake carrying a key code and press/release flag.
interface keypad_scanner_if #(
    parameter int unsigned CODE_W = 4
);
    logic              ev_valid;
    logic              ev_ready;
    logic [CODE_W-1:0] ev_code;
    logic              ev_press;

    modport master (output ev_valid, ev_code, ev_press, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_press, output ev_ready);
endinterface

// File: rtl/keypad_event_fifo.sv
// Synchronous event FIFO with registered head, valid/ready pop, and push accepted when full
// only if the head is popped in the same cycle.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             drop_c,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o,
    input  logic             rready_i
);
    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d, remain_c;
    logic             valid_q;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             full_c, do_pop_c, do_push_c;

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign do_pop_c  = valid_q & rready_i;
    assign do_push_c = push_i & (~full_c | do_pop_c);
    assign drop_c    = push_i & full_c & ~do_pop_c;
    assign rvalid_o  = valid_q;
    assign rdata_o   = rdata_q;

    // Head register follows the oldest entry; holds its last value once the FIFO drains.
    always_comb begin
        remain_c = count_q - CNT_W'(do_pop_c);
        count_d  = remain_c + CNT_W'(do_push_c);
        rptr_d   = rptr_q + PTR_W'(do_pop_c);
        rdata_d  = rdata_q;
        if (remain_c != '0) begin
            rdata_d = mem_q[rptr_d];
        end else if (do_push_c) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PTR_W'(do_push_c);
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ROWS x COLS keypad scanner with per-key debounce, n-key rollover and an event FIFO.
// Define KEYPAD_SCANNER_RELEASE_EN to also queue release events.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_DIV   = 16,
    parameter int unsigned DEBOUNCE   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] cols_o,
    input  logic [ROWS-1:0] rows_i,
    output logic            key_down_o,
    output logic            overflow_o,
    input  logic            ovf_clr_i,
    keypad_scanner_if.master ev
);
    localparam int unsigned NKEYS      = ROWS * COLS;
    localparam int unsigned CODE_W     = clog2_min1(NKEYS);
    localparam int unsigned PH_W       = clog2_min1(SCAN_DIV);
    localparam int unsigned CI_W       = clog2_min1(COLS);
    localparam int unsigned RW_W       = clog2_min1(ROWS);
    localparam int unsigned CNT_W      = clog2_min1(DEBOUNCE);
    localparam int unsigned EVAL_START = SCAN_DIV - ROWS;
    localparam int unsigned SAMPLE_PH  = SCAN_DIV - ROWS - 1;

`ifdef KEYPAD_SCANNER_RELEASE_EN
    localparam logic RELEASE_EN = 1'b1;
`else
    localparam logic RELEASE_EN = 1'b0;
`endif

    logic [PH_W-1:0]   phase_q;
    logic [CI_W-1:0]   col_idx_q;
    logic [COLS-1:0]   cols_q;
    logic [ROWS-1:0]   sync1_q, sync2_q, sample_q;
    logic [NKEYS-1:0]  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NKEYS];
    logic [CNT_W-1:0]  cnt_d [NKEYS];
    logic              push_q, push_d;
    logic              pend_press_q, pend_press_d;
    logic [CODE_W-1:0] pend_code_q, pend_code_d;
    logic              key_down_q, overflow_q;
    logic              eval_c, drop_c;
    logic [RW_W-1:0]   row_c;
    logic [CODE_W-1:0] key_c;
    logic [CODE_W:0]   fifo_rdata_c;

    assign cols_o     = cols_q;
    assign key_down_o = key_down_q;
    assign overflow_o = overflow_q;

    // Column dwell counter, one-hot column rotation and row synchroniser/sampler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= '0;
            col_idx_q <= '0;
            cols_q    <= COLS'(COL_RESET);
            sync1_q   <= '0;
            sync2_q   <= '0;
            sample_q  <= '0;
        end else begin
            sync1_q <= rows_i;
            sync2_q <= sync1_q;
            if (phase_q == PH_W'(SAMPLE_PH)) begin
                sample_q <= sync2_q;
            end
            if (phase_q == PH_W'(SCAN_DIV - 1)) begin
                phase_q   <= '0;
                cols_q    <= (cols_q << 1) | (cols_q >> (COLS - 1));
                col_idx_q <= (col_idx_q == CI_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    assign eval_c = (phase_q >= PH_W'(EVAL_START));
    assign row_c  = RW_W'(phase_q - PH_W'(EVAL_START));
    assign key_c  = CODE_W'(32'(col_idx_q) * ROWS + 32'(row_c));

    // One key judged per evaluation phase, so at most one flip/event per clock.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        push_d       = 1'b0;
        pend_press_d = pend_press_q;
        pend_code_d  = pend_code_q;
        if (eval_c) begin
            if (sample_q[row_c] == state_q[key_c]) begin
                cnt_d[key_c] = '0;
            end else if (cnt_q[key_c] == CNT_W'(DEBOUNCE - 1)) begin
                cnt_d[key_c]   = '0;
                state_d[key_c] = sample_q[row_c];
                push_d         = sample_q[row_c] | RELEASE_EN;
                pend_press_d   = sample_q[row_c];
                pend_code_d    = key_c;
            end else begin
                cnt_d[key_c] = cnt_q[key_c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '0;
            for (int k = 0; k < int'(NKEYS); k++) begin
                cnt_q[k] <= '0;
            end
            push_q       <= 1'b0;
            pend_press_q <= 1'b0;
            pend_code_q  <= '0;
            key_down_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            push_q       <= push_d;
            pend_press_q <= pend_press_d;
            pend_code_q  <= pend_code_d;
            key_down_q   <= |state_q;
            overflow_q   <= drop_c | (overflow_q & ~ovf_clr_i);
        end
    end

    keypad_event_fifo #(
        .WIDTH (CODE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push_q),
        .wdata_i  ({pend_press_q, pend_code_q}),
        .drop_c   (drop_c),
        .rvalid_o (ev.ev_valid),
        .rdata_o  (fifo_rdata_c),
        .rready_i (ev.ev_ready)
    );

    assign ev.ev_code  = fifo_rdata_c[CODE_W-1:0];
    // Press-only builds report every event as a press.
    assign ev.ev_press = fifo_rdata_c[CODE_W] | ~RELEASE_EN;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (4x4, SCAN_DIV 16, DEBOUNCE 3, FIFO 4).
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        key_down;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] pressed;

    int errors = 0;
    int checks = 0;
    logic [4:0] evq[$];

    keypad_scanner_if #(.CODE_W(4)) ev ();

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(16), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cols_o     (cols),
        .rows_i     (rows),
        .key_down_o (key_down),
        .overflow_o (overflow),
        .ovf_clr_i  (ovf_clr),
        .ev         (ev)
    );

    always #5 clk = ~clk;

    // Ideal key matrix: a pressed key shorts its column to its row.
    always_comb begin
        rows = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (cols[c] && pressed[c*4 + r]) rows[r] = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && ev.ev_valid && ev.ev_ready) evq.push_back({ev.ev_press, ev.ev_code});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic align_scan();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev = cols;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (cols == 4'b0001 && prev == 4'b1000) found = 1'b1;
            prev = cols;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL align_scan: column 0 start not seen, cols=%b", cols);
        end
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget && evq.size() < n; i++) step();
    endtask

    function automatic logic [4:0] ev_at(input int idx);
        return (evq.size() > idx) ? evq[idx] : 5'h1F;
    endfunction

    task automatic test_reset();
        rst = 1'b1; pressed = '0; ev.ev_ready = 1'b0; ovf_clr = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        align_scan();
        pressed[0] = 1'b1;
        wait_cycles(260);
        checks++;
        if (key_down !== 1'b1 || ev.ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_press: key_down=%b ev_valid=%b, required 1/1", key_down, ev.ev_valid);
        end
        wait_cycles(21);
        rst = 1'b1;
        step();
        checks++;
        if (cols !== 4'b0001) begin errors++; $display("FAIL reset_cols: got %b, required 0001", cols); end
        checks++;
        if (ev.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b, required 0", ev.ev_valid); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        checks++;
        if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b, required 0", key_down); end
        checks++;
        if (ev.ev_code !== 4'd0) begin errors++; $display("FAIL reset_ev_code: got %0d, required 0", ev.ev_code); end
        pressed = '0;
        rst = 1'b0;
        wait_cycles(5);
        checks++;
        if (cols !== 4'b0001) begin errors++; $display("FAIL post_reset_dwell: got %b, required 0001", cols); end
        wait_cycles(200);
        checks++;
        if (ev.ev_valid !== 1'b0 || evq.size() != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: ev_valid=%b events=%0d, required 0/0", ev.ev_valid, evq.size());
        end
    endtask

    task automatic test_single_press();
        ev.ev_ready = 1'b1;
        evq.delete();
        align_scan();
        pressed[9] = 1'b1;
        wait_events(1, 300);
        checks++;
        if (evq.size() != 1) begin errors++; $display("FAIL single_count: got %0d events, required 1", evq.size()); end
        checks++;
        if (ev_at(0) !== {1'b1, 4'd9}) begin
            errors++;
            $display("FAIL single_event: got press=%b code=%0d, required press=1 code=9", ev_at(0)[4], ev_at(0)[3:0]);
        end
        checks++;
        if (key_down !== 1'b1) begin errors++; $display("FAIL single_key_down: got %b, required 1", key_down); end
        wait_cycles(130);
        checks++;
        if (evq.size() != 1) begin errors++; $display("FAIL single_held_repeat: got %0d events, required 1", evq.size()); end
        pressed[9] = 1'b0;
        wait_cycles(300);
        checks++;
        if (key_down !== 1'b0) begin errors++; $display("FAIL single_release_key_down: got %b, required 0", key_down); end
        evq.delete();
    endtask

    task automatic test_bounce();
        evq.delete();
        align_scan();
        pressed[5] = 1'b1;
        wait_cycles(120);
        pressed[5] = 1'b0;
        wait_cycles(200);
        checks++;
        if (evq.size() != 0) begin errors++; $display("FAIL bounce_events: got %0d, required 0", evq.size()); end
        checks++;
        if (key_down !== 1'b0) begin errors++; $display("FAIL bounce_key_down: got %b, required 0", key_down); end
    endtask

    task automatic test_two_keys();
        evq.delete();
        align_scan();
        pressed[0] = 1'b1;
        pressed[15] = 1'b1;
        wait_events(2, 300);
        checks++;
        if (evq.size() != 2) begin errors++; $display("FAIL two_count: got %0d events, required 2", evq.size()); end
        checks++;
        if (ev_at(0) !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL two_first: got press=%b code=%0d, required press=1 code=0", ev_at(0)[4], ev_at(0)[3:0]);
        end
        checks++;
        if (ev_at(1) !== {1'b1, 4'd15}) begin
            errors++;
            $display("FAIL two_second: got press=%b code=%0d, required press=1 code=15", ev_at(1)[4], ev_at(1)[3:0]);
        end
        pressed = '0;
        wait_cycles(300);
        evq.delete();
    endtask

    task automatic test_overflow();
        logic [4:0] exp_ev [4];
        exp_ev[0] = {1'b1, 4'd1}; exp_ev[1] = {1'b1, 4'd2};
        exp_ev[2] = {1'b1, 4'd3}; exp_ev[3] = {1'b1, 4'd4};
        ev.ev_ready = 1'b0;
        evq.delete();
        align_scan();
        pressed = 16'h003E;
        wait_cycles(220);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        checks++;
        if (ev.ev_valid !== 1'b1 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL ovf_valid_keydown: ev_valid=%b key_down=%b, required 1/1", ev.ev_valid, key_down);
        end
        ev.ev_ready = 1'b1;
        wait_cycles(10);
        checks++;
        if (evq.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d events, required 4", evq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_at(i) !== exp_ev[i]) begin
                errors++;
                $display("FAIL ovf_entry%0d: got press=%b code=%0d, required press=1 code=%0d",
                         i, ev_at(i)[4], ev_at(i)[3:0], exp_ev[i][3:0]);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
        pressed = '0;
        wait_cycles(300);
        evq.delete();
    endtask

    task automatic test_release();
        int exp_n;
`ifdef KEYPAD_SCANNER_RELEASE_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        ev.ev_ready = 1'b1;
        evq.delete();
        align_scan();
        pressed[6] = 1'b1;
        wait_cycles(260);
        pressed[6] = 1'b0;
        wait_cycles(300);
        checks++;
        if (evq.size() != exp_n) begin errors++; $display("FAIL release_count: got %0d events, required %0d", evq.size(), exp_n); end
        checks++;
        if (ev_at(0) !== {1'b1, 4'd6}) begin
            errors++;
            $display("FAIL release_press: got press=%b code=%0d, required press=1 code=6", ev_at(0)[4], ev_at(0)[3:0]);
        end
`ifdef KEYPAD_SCANNER_RELEASE_EN
        checks++;
        if (ev_at(1) !== {1'b0, 4'd6}) begin
            errors++;
            $display("FAIL release_event: got press=%b code=%0d, required press=0 code=6", ev_at(1)[4], ev_at(1)[3:0]);
        end
`endif
        checks++;
        if (key_down !== 1'b0) begin errors++; $display("FAIL release_key_down: got %b, required 0", key_down); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_overflow();
        test_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
